// File: rtl/soc_system_hex_master.sv
// soc_system_hex_master
// Avalon-MM initiator that refreshes a bank of 7-segment HEX PIO responders.
// A start strobe captures a binary value; each nibble is converted to an
// active-low segment code and written to its responder, digit 0 first.
//
// Optional build macro: HEX_MASTER_READBACK_EN
//   Defined   : every write is followed by a read of the same address. A
//               mismatch on readdata[6:0] sets the sticky err flag.
//   Undefined : writes only; err is tied 0 and avm_read_n is tied 1.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   start            one-cycle request, accepted only while busy=0
//   value            4*NUM_DIGITS bits, nibble i drives digit i
//   blank_lz         1 = blank leading zeros (digit 0 is never blanked)
//   busy             high in every state except IDLE
//   done             one-cycle pulse after the last transfer completes
//   err              sticky readback mismatch flag
//   avm_*            Avalon-MM initiator port (word addresses)
//   state_dbg        current FSM state, for checkers
//
// Handshake: a transfer is requested while avm_chipselect=1. All bus
// outputs stay stable while avm_waitrequest=1; the transfer completes in
// the first cycle where avm_waitrequest=0, and avm_readdata is sampled in
// that same cycle.
module soc_system_hex_master #(
    parameter int NUM_DIGITS = 6,
    parameter int ADDR_W     = 8,
    parameter int BASE_ADDR  = 0,
    parameter int STRIDE     = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_W-1:0]       avm_address,
    output logic                    avm_chipselect,
    output logic                    avm_write_n,
    output logic                    avm_read_n,
    output logic [31:0]             avm_writedata,
    input  logic [31:0]             avm_readdata,
    input  logic                    avm_waitrequest,
    output logic [1:0]              state_dbg
);

    localparam int VW    = 4 * NUM_DIGITS;
    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
`ifdef HEX_MASTER_READBACK_EN
        ,
        READ  = 2'd3
`endif
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [VW-1:0]      val_q;
    logic               blz_q;
    logic               advance;

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // A digit above 0 is blank when it and every more significant nibble
    // are zero, i.e. the value shifted down to this digit is zero.
    function automatic logic [6:0] digit_code(input logic [VW-1:0] v,
                                              input logic blz,
                                              input logic [IDX_W-1:0] i);
        logic [VW-1:0] upper;
        upper = v >> (4 * i);
        if (blz && (i != '0) && (upper == '0))
            return 7'h7F;
        return seg_code(upper[3:0]);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] i);
        logic [31:0] full;
        full = 32'(BASE_ADDR) + 32'(i) * 32'(STRIDE);
        return full[ADDR_W-1:0];
    endfunction

    // The step that finishes one digit: the write itself, or its readback.
`ifdef HEX_MASTER_READBACK_EN
    assign advance = (state == READ) && !avm_waitrequest;
`else
    assign advance = (state == WRITE) && !avm_waitrequest;
`endif

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            idx            <= '0;
            val_q          <= '0;
            blz_q          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= '0;
            avm_writedata  <= '0;
`ifdef HEX_MASTER_READBACK_EN
            avm_read_n     <= 1'b1;
            err            <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        val_q          <= value;
                        blz_q          <= blank_lz;
                        idx            <= '0;
                        busy           <= 1'b1;
                        state          <= WRITE;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= addr_of('0);
                        avm_writedata  <= {25'b0, digit_code(value, blank_lz, '0)};
`ifdef HEX_MASTER_READBACK_EN
                        err            <= 1'b0;
`endif
                    end
                end
                WRITE: begin
`ifdef HEX_MASTER_READBACK_EN
                    // Same address, turn the write into a read; writedata
                    // keeps the code for the comparison.
                    if (!avm_waitrequest) begin
                        avm_write_n <= 1'b1;
                        avm_read_n  <= 1'b0;
                        state       <= READ;
                    end
`endif
                end
`ifdef HEX_MASTER_READBACK_EN
                READ: begin
                    if (!avm_waitrequest) begin
                        avm_read_n <= 1'b1;
                        if (avm_readdata[6:0] != avm_writedata[6:0])
                            err <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Overrides the per-state assignments above when a digit ends.
            if (advance) begin
                if (idx == LAST_IDX) begin
                    avm_chipselect <= 1'b0;
                    avm_write_n    <= 1'b1;
                    avm_address    <= '0;
                    avm_writedata  <= '0;
                    done           <= 1'b1;
                    state          <= DONE;
                end else begin
                    idx            <= idx + 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= addr_of(idx + 1'b1);
                    avm_writedata  <= {25'b0, digit_code(val_q, blz_q, idx + 1'b1)};
                    state          <= WRITE;
                end
            end
        end
    end

`ifdef HEX_MASTER_READBACK_EN
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:7];
`else
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata;
    assign avm_read_n      = 1'b1;
    assign err             = 1'b0;
`endif

endmodule
